phase_sequencer: RTL and testbench

- Instruction-cycle controller for the team microprocessor.
- Steps each instruction through four phases: Fetch, Decode, Execute, Writeback.
- Drives one-hot phase lines and the datapath control strobes.
- Handles the memory fetch handshake, multi-cycle execute, stalls, halt and fetch-timeout fault.
- Sits between the instruction memory interface and the register/ALU datapath; replaces free-running phase generation with instruction-aware sequencing.

---
 rtl/phase_sequencer.sv | 139 +++++++++++++
 tb/tb_phase_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction-cycle controller: sequences FETCH/DECODE/EXECUTE/WRITEBACK with
// fetch handshake, timed execute, datapath stall, halt and fetch-timeout fault.
module phase_sequencer #(
    parameter int         EXEC_CYCLES   = 3,
    parameter int         FETCH_TIMEOUT = 15,
    parameter logic [3:0] HALT_OP       = 4'hF
) (
    input  logic       Phase_Count,
    input  logic       Clear,
    input  logic       Run,
    input  logic       Mem_Ack,
    input  logic [3:0] Opcode,
    input  logic       Stall,
    output logic       Phase0,
    output logic       Phase1,
    output logic       Phase2,
    output logic       Phase3,
    output logic       Mem_Req,
    output logic       IR_Load,
    output logic       PC_Inc,
    output logic       ALU_En,
    output logic       Reg_Write,
    output logic       Halted,
    output logic       Fault,
    output logic [7:0] Instr_Count
);

    // One-hot encoding so every Moore output is a single state flop.
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_FETCH  = 6'b000010,
        S_DECODE = 6'b000100,
        S_EXEC   = 6'b001000,
        S_WB     = 6'b010000,
        S_HALT   = 6'b100000
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [3:0] EXEC_LD  = 4'(EXEC_CYCLES);

    state_t     r_state, w_next;
    logic [7:0] r_tmo, w_tmo;
    logic [3:0] r_exec, w_exec;
    logic [3:0] r_opcode, w_opcode;
    logic [7:0] r_count, w_count;
    logic       r_fault, w_fault;

    always_ff @(posedge Phase_Count or posedge Clear) begin
        if (Clear) begin
            r_state  <= S_IDLE;
            r_tmo    <= '0;
            r_exec   <= '0;
            r_opcode <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tmo    <= w_tmo;
            r_exec   <= w_exec;
            r_opcode <= w_opcode;
            r_count  <= w_count;
            r_fault  <= w_fault;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_tmo    = r_tmo;
        w_exec   = r_exec;
        w_opcode = r_opcode;
        w_count  = r_count;
        w_fault  = r_fault;
        IR_Load  = 1'b0;
        PC_Inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) w_next = S_FETCH;
            end
            S_FETCH: begin
                IR_Load = Mem_Ack;
                PC_Inc  = Mem_Ack;
                if (Mem_Ack) begin
                    w_next = S_DECODE;
                end else if (r_tmo == TMO_LAST) begin
                    w_next  = S_HALT;
                    w_fault = 1'b1;
                end else begin
                    w_tmo = r_tmo + 8'd1;
                end
            end
            S_DECODE: begin
                if (!Stall) begin
                    w_opcode = Opcode;
                    if (Opcode == HALT_OP) begin
                        w_next = S_HALT;
                    end else if (Opcode == 4'h0) begin
                        w_count = r_count + 8'd1;
                        w_next  = Run ? S_FETCH : S_IDLE;
                    end else begin
                        w_next = S_EXEC;
                        w_exec = Opcode[3] ? EXEC_LD : 4'd1;
                    end
                end
            end
            S_EXEC: begin
                if (!Stall) begin
                    if (r_exec == 4'd1) w_next = S_WB;
                    else                w_exec = r_exec - 4'd1;
                end
            end
            S_WB: begin
                // Retire only on the exit edge, however long the stall lasts.
                if (!Stall) begin
                    w_count = r_count + 8'd1;
                    w_next  = Run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: ;
            default: w_next = S_IDLE;
        endcase
        if (w_next == S_FETCH && r_state != S_FETCH) w_tmo = '0;
    end

    // Latched opcode is held for datapath debug visibility only.
    logic w_opcode_unused;
    assign w_opcode_unused = ^r_opcode;

    assign Phase0      = r_state[1];
    assign Phase1      = r_state[2];
    assign Phase2      = r_state[3];
    assign Phase3      = r_state[4];
    assign Halted      = r_state[5];
    assign Mem_Req     = r_state[1];
    assign ALU_En      = r_state[3];
    assign Reg_Write   = r_state[4];
    assign Fault       = r_fault;
    assign Instr_Count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: phase order, instruction lengths, stalls,
// NOP/HALT decode, fetch timeout, counter wrap and asynchronous Clear.
module tb_phase_sequencer;

    logic       Phase_Count, Clear, Run, Mem_Ack, Stall;
    logic [3:0] Opcode;
    logic       Phase0, Phase1, Phase2, Phase3, Mem_Req, IR_Load, PC_Inc;
    logic       ALU_En, Reg_Write, Halted, Fault;
    logic [7:0] Instr_Count;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt;

    phase_sequencer #(.EXEC_CYCLES(3), .FETCH_TIMEOUT(15), .HALT_OP(4'hF)) dut (
        .Phase_Count(Phase_Count), .Clear(Clear), .Run(Run), .Mem_Ack(Mem_Ack),
        .Opcode(Opcode), .Stall(Stall),
        .Phase0(Phase0), .Phase1(Phase1), .Phase2(Phase2), .Phase3(Phase3),
        .Mem_Req(Mem_Req), .IR_Load(IR_Load), .PC_Inc(PC_Inc), .ALU_En(ALU_En),
        .Reg_Write(Reg_Write), .Halted(Halted), .Fault(Fault),
        .Instr_Count(Instr_Count)
    );

    logic [3:0]  w_phase;
    logic [18:0] w_all;
    assign w_phase = {Phase3, Phase2, Phase1, Phase0};
    assign w_all   = {w_phase, Mem_Req, IR_Load, PC_Inc, ALU_En, Reg_Write,
                      Halted, Fault, Instr_Count};

    initial begin
        Phase_Count = 1'b0;
        forever #5 Phase_Count = ~Phase_Count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in FETCH; runs until FETCH is seen again (bounded).
    task automatic run_instr(input logic [3:0] op, input int s_at, input int s_len,
                             output int cyc, output int alu, output int rw);
        Opcode = op;
        cyc = 0; alu = 0; rw = 0;
        do begin
            alu += int'(ALU_En);
            rw  += int'(Reg_Write);
            Stall = (cyc >= s_at) && (cyc < s_at + s_len);
            @(negedge Phase_Count);
            cyc++;
        end while (!Phase0 && cyc < 40);
        Stall = 1'b0;
    endtask

    task automatic do_instr(input string tag, input logic [3:0] op, input int s_at,
                            input int s_len, input int e_cyc, input int e_alu,
                            input int e_rw);
        int cyc, alu, rw;
        run_instr(op, s_at, s_len, cyc, alu, rw);
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, "_cycles"}, cyc, e_cyc);
        chk({tag, "_alu"}, alu, e_alu);
        chk({tag, "_rw"}, rw, e_rw);
        chk({tag, "_count"}, Instr_Count, exp_cnt);
    endtask

    initial begin
        int cyc, alu, rw, n, mreq;
        Clear = 1'b1; Run = 1'b0; Mem_Ack = 1'b0; Opcode = 4'h0; Stall = 1'b0;
        exp_cnt = 8'd0;
        repeat (2) @(negedge Phase_Count);
        chk("reset_all", w_all, 19'd0);

        Clear = 1'b0; Run = 1'b1; Mem_Ack = 1'b1; Opcode = 4'h1;
        @(negedge Phase_Count);
        chk("first_fetch_req", {Mem_Req, IR_Load, PC_Inc}, 3'b111);
        for (int i = 0; i < 12; i++) begin
            chk("short_phase", w_phase, 4'b0001 << (i % 4));
            chk("short_rw", Reg_Write, (i % 4) == 3);
            @(negedge Phase_Count);
        end
        exp_cnt = 8'd3;
        chk("short_count3", Instr_Count, exp_cnt);

        do_instr("long",       4'h9, 99, 0, 6, 3, 1);
        do_instr("stall_ex",   4'h9,  2, 2, 8, 5, 1);
        do_instr("nop",        4'h0, 99, 0, 2, 0, 0);
        do_instr("stall_wb",   4'h1,  3, 2, 6, 1, 3);
        do_instr("stall_fetch",4'h1,  0, 1, 4, 1, 1);

        n = 255 - int'(exp_cnt);
        repeat (n) run_instr(4'h1, 99, 0, cyc, alu, rw);
        chk("wrap_255", Instr_Count, 8'd255);
        run_instr(4'h1, 99, 0, cyc, alu, rw);
        chk("wrap_0", Instr_Count, 8'd0);
        exp_cnt = 8'd0;

        // Run dropped mid-instruction: finish then IDLE.
        Opcode = 4'h1;
        @(negedge Phase_Count);
        Run = 1'b0;
        repeat (3) @(negedge Phase_Count);
        chk("runoff_idle", {w_phase, Mem_Req, Halted}, 6'd0);
        chk("runoff_count", Instr_Count, 8'd1);
        @(negedge Phase_Count);
        chk("runoff_stay", w_phase, 4'd0);
        Run = 1'b1;
        @(negedge Phase_Count);
        chk("run_restart", {w_phase, Mem_Req}, 5'b00011);

        Opcode = 4'hF;
        repeat (2) @(negedge Phase_Count);
        chk("haltop", {w_phase, Halted, Fault}, 6'b000010);
        chk("haltop_count", Instr_Count, 8'd1);
        for (int i = 0; i < 4; i++) begin
            Run = ~Run;
            @(negedge Phase_Count);
        end
        chk("haltop_stay", {w_phase, Halted}, 5'b00001);

        Clear = 1'b1;
        #1;
        chk("clear_halt", w_all, 19'd0);
        @(negedge Phase_Count);
        Clear = 1'b0; Run = 1'b1; Mem_Ack = 1'b0;
        n = 0; mreq = 0;
        while (!Halted && n < 40) begin
            mreq += int'(Mem_Req);
            @(negedge Phase_Count);
            n++;
        end
        chk("tmo_mreq", mreq, 15);
        chk("tmo_state", {w_phase, Mem_Req, Halted, Fault}, 7'b0000011);
        for (int i = 0; i < 4; i++) begin
            Run = ~Run; Mem_Ack = 1'b1;
            @(negedge Phase_Count);
        end
        chk("tmo_stay", {w_phase, Halted, Fault}, 6'b000011);

        Clear = 1'b1;
        @(negedge Phase_Count);
        Clear = 1'b0; Run = 1'b1; Mem_Ack = 1'b1; Opcode = 4'h9;
        repeat (3) @(negedge Phase_Count);
        chk("pre_clear_exec", {w_phase, ALU_En}, 5'b01001);
        #2 Clear = 1'b1;
        #1;
        chk("clear_exec", w_all, 19'd0);
        @(negedge Phase_Count);
        Clear = 1'b0;
        @(negedge Phase_Count);
        chk("post_clear_fetch", {w_phase, Mem_Req}, 5'b00011);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
